// File: rtl/norm_shifter.sv
// Leading-zero normalizer: shifts an operand left until its MSB is set and reports the shift count.
// Optional nibble fast path enabled by defining NORM_NIBBLE_EN.
module norm_shifter #(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned CNT_W = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] norm_result,
  output logic [CNT_W-1:0]  lz_count,
  output logic              zero
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]        state, state_nx;
  logic [DATA_W-1:0] work, work_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              zf, zf_nx;

  // Next-state and working-register update
  always_comb begin
    state_nx = state;
    work_nx  = work;
    cnt_nx   = cnt;
    zf_nx    = zf;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          work_nx = data;
          cnt_nx  = '0;
          zf_nx   = 1'b0;
          if (data == '0) begin
            zf_nx    = 1'b1;
            cnt_nx   = CNT_W'(DATA_W);
            state_nx = DONE;
          end else if (data[DATA_W-1]) begin
            state_nx = DONE;
          end else begin
            state_nx = SHIFT;
          end
        end
      end
      SHIFT: begin
`ifdef NORM_NIBBLE_EN
        if (work[DATA_W-1 -: 4] == 4'd0) begin
          work_nx = work << 4;
          cnt_nx  = cnt + CNT_W'(4);
          if (work[DATA_W-5]) state_nx = DONE;
        end else
`endif
        begin
          work_nx = work << 1;
          cnt_nx  = cnt + CNT_W'(1);
          if (work[DATA_W-2]) state_nx = DONE;
        end
      end
      DONE: begin
        if (out_valid && out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and registered outputs; results latch once on entry to DONE and hold until handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      work        <= '0;
      cnt         <= '0;
      zf          <= 1'b0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      norm_result <= '0;
      lz_count    <= '0;
      zero        <= 1'b0;
    end else begin
      state     <= state_nx;
      work      <= work_nx;
      cnt       <= cnt_nx;
      zf        <= zf_nx;
      in_ready  <= (state_nx == IDLE);
      out_valid <= (state == DONE) && (state_nx == DONE);
      if ((state == DONE) && !out_valid) begin
        norm_result <= work;
        lz_count    <= cnt;
        zero        <= zf;
      end
    end
  end

endmodule
